// File: rtl/dds_cfg_ctrl.sv
// dds_cfg_ctrl: start-triggered sequencer that waits for a fresh FFT
// separation result, range-checks both frequency codes and loads the
// dual-channel DDS wave, frequency and phase selects.
// Optional feature macro: PHASE_TRIM_EN enables the channel 2 phase trim
// (phase_up / phase_down) while the regenerated outputs are running.
module dds_cfg_ctrl #(
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int FREQ_MIN       = 4,
    parameter int FREQ_MAX       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       wave_vaild,
    input  logic [7:0] waveA_freq,
    input  logic       waveA_sin,
    input  logic [7:0] waveB_freq,
    input  logic       waveB_sin,
    input  logic       phase_up,
    input  logic       phase_down,
    output logic       wave_select1,
    output logic       wave_select2,
    output logic [7:0] freq_select1,
    output logic [7:0] freq_select2,
    output logic [5:0] phase_select1,
    output logic [5:0] phase_select2,
    output logic       busy,
    output logic       cfg_done,
    output logic       err
);

    // A timeout of one cycle would give $clog2 = 0; keep at least one bit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VALID,
        CHECK,
        RUN,
        ERROR
    } state_t;

    state_t           state;
    logic             armed;
    logic [CNT_W-1:0] tmo_cnt;

    // Separation result captured on the accepted valid, checked in CHECK.
    logic [7:0] a_freq_p1;
    logic [7:0] b_freq_p1;
    logic       a_sin_p1;
    logic       b_sin_p1;

    function automatic logic freq_ok(input logic [7:0] code);
        return (code >= 8'(FREQ_MIN)) && (code <= 8'(FREQ_MAX));
    endfunction

`ifndef PHASE_TRIM_EN
    // Trim inputs have no function in this build.
    logic unused_phase_in;
    assign unused_phase_in = phase_up | phase_down;
`endif

    // Sequencer FSM with all outputs registered; start overrides every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            armed         <= 1'b0;
            tmo_cnt       <= '0;
            a_freq_p1     <= '0;
            b_freq_p1     <= '0;
            a_sin_p1      <= 1'b0;
            b_sin_p1      <= 1'b0;
            wave_select1  <= 1'b0;
            wave_select2  <= 1'b0;
            freq_select1  <= '0;
            freq_select2  <= '0;
            phase_select1 <= '0;
            phase_select2 <= '0;
            busy          <= 1'b0;
            cfg_done      <= 1'b0;
            err           <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            if (start) begin
                // (Re)start: a phase pulse in the same cycle is dropped.
                state   <= WAIT_VALID;
                busy    <= 1'b1;
                err     <= 1'b0;
                armed   <= 1'b0;
                tmo_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    WAIT_VALID: begin
                        if (armed && wave_vaild) begin
                            a_freq_p1 <= waveA_freq;
                            a_sin_p1  <= waveA_sin;
                            b_freq_p1 <= waveB_freq;
                            b_sin_p1  <= waveB_sin;
                            tmo_cnt   <= '0;
                            state     <= CHECK;
                        end else if (tmo_cnt == CNT_LAST) begin
                            tmo_cnt <= '0;
                            busy    <= 1'b0;
                            err     <= 1'b1;
                            state   <= ERROR;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                        // A low sample proves the next high is a fresh result.
                        if (!wave_vaild) begin
                            armed <= 1'b1;
                        end
                    end
                    CHECK: begin
                        busy <= 1'b0;
                        if (freq_ok(a_freq_p1) && freq_ok(b_freq_p1)) begin
                            wave_select1  <= a_sin_p1;
                            wave_select2  <= b_sin_p1;
                            freq_select1  <= a_freq_p1;
                            freq_select2  <= b_freq_p1;
                            phase_select1 <= '0;
                            phase_select2 <= '0;
                            cfg_done      <= 1'b1;
                            state         <= RUN;
                        end else begin
                            err   <= 1'b1;
                            state <= ERROR;
                        end
                    end
                    RUN: begin
`ifdef PHASE_TRIM_EN
                        // 6-bit wrap gives modulo-64 stepping in both directions.
                        if (phase_up && !phase_down) begin
                            phase_select2 <= phase_select2 + 6'd1;
                        end else if (phase_down && !phase_up) begin
                            phase_select2 <= phase_select2 - 6'd1;
                        end
`endif
                    end
                    ERROR: begin
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dds_cfg_ctrl.sv
// Directed self-checking bench for dds_cfg_ctrl (timeout shortened to 16).
module tb_dds_cfg_ctrl;

`ifdef PHASE_TRIM_EN
    localparam bit TRIM = 1'b1;
`else
    localparam bit TRIM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       wave_vaild;
    logic [7:0] waveA_freq;
    logic       waveA_sin;
    logic [7:0] waveB_freq;
    logic       waveB_sin;
    logic       phase_up;
    logic       phase_down;
    logic       wave_select1;
    logic       wave_select2;
    logic [7:0] freq_select1;
    logic [7:0] freq_select2;
    logic [5:0] phase_select1;
    logic [5:0] phase_select2;
    logic       busy;
    logic       cfg_done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    dds_cfg_ctrl #(
        .TIMEOUT_CYCLES(16),
        .FREQ_MIN(4),
        .FREQ_MAX(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .wave_vaild(wave_vaild),
        .waveA_freq(waveA_freq),
        .waveA_sin(waveA_sin),
        .waveB_freq(waveB_freq),
        .waveB_sin(waveB_sin),
        .phase_up(phase_up),
        .phase_down(phase_down),
        .wave_select1(wave_select1),
        .wave_select2(wave_select2),
        .freq_select1(freq_select1),
        .freq_select2(freq_select2),
        .phase_select1(phase_select1),
        .phase_select2(phase_select2),
        .busy(busy),
        .cfg_done(cfg_done),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_waves(input logic [7:0] af, input logic as, input logic [7:0] bf, input logic bs);
        waveA_freq = af;
        waveA_sin  = as;
        waveB_freq = bf;
        waveB_sin  = bs;
    endtask

    // start, one low valid sample to arm, one high sample to capture.
    // Returns with the DUT leaving CHECK at the next edge.
    task automatic start_and_capture();
        start      = 1'b1;
        wave_vaild = 1'b0;
        tick();
        start = 1'b0;
        tick();
        wave_vaild = 1'b1;
        tick();
        wave_vaild = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        wave_vaild = 1'b0;
        phase_up   = 1'b0;
        phase_down = 1'b0;
        set_waves(8'd0, 1'b0, 8'd0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_freq1", freq_select1, 0);
        chk("rst_freq2", freq_select2, 0);
        chk("rst_wave1", wave_select1, 0);
        chk("rst_phase2", phase_select2, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_done", cfg_done, 0);
        chk("rst_err", err, 0);

        // Basic load: A=8 sine, B=12 triangle
        set_waves(8'd8, 1'b1, 8'd12, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s1_busy_after_start", busy, 1);
        tick();
        wave_vaild = 1'b1;
        tick();
        wave_vaild = 1'b0;
        chk("s1_check_busy", busy, 1);
        chk("s1_check_no_done", cfg_done, 0);
        tick();
        chk("s1_done", cfg_done, 1);
        chk("s1_freq1", freq_select1, 8);
        chk("s1_wave1", wave_select1, 1);
        chk("s1_freq2", freq_select2, 12);
        chk("s1_wave2", wave_select2, 0);
        chk("s1_busy_off", busy, 0);
        chk("s1_phase1", phase_select1, 0);
        tick();
        chk("s1_done_pulse", cfg_done, 0);

        // Valid held high across start: stale result must not be used
        set_waves(8'd10, 1'b0, 8'd16, 1'b1);
        wave_vaild = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("s2_still_busy", busy, 1);
        chk("s2_no_reuse", freq_select1, 8);
        chk("s2_no_done", cfg_done, 0);
        wave_vaild = 1'b0;
        tick();
        wave_vaild = 1'b1;
        tick();
        wave_vaild = 1'b0;
        tick();
        chk("s2_done", cfg_done, 1);
        chk("s2_freq1", freq_select1, 10);
        chk("s2_wave1", wave_select1, 0);
        chk("s2_freq2", freq_select2, 16);
        chk("s2_wave2", wave_select2, 1);

        // A below FREQ_MIN -> error, outputs retained
        set_waves(8'd3, 1'b1, 8'd12, 1'b0);
        start_and_capture();
        tick();
        chk("s3_err", err, 1);
        chk("s3_busy", busy, 0);
        chk("s3_no_done", cfg_done, 0);
        chk("s3_keep_freq1", freq_select1, 10);
        chk("s3_keep_freq2", freq_select2, 16);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s3_err_cleared", err, 0);
        chk("s3_busy_again", busy, 1);

        // Boundary codes 4 and 20 are legal
        tick();
        set_waves(8'd4, 1'b0, 8'd20, 1'b1);
        wave_vaild = 1'b1;
        tick();
        wave_vaild = 1'b0;
        tick();
        chk("s3_edge_done", cfg_done, 1);
        chk("s3_edge_freq1", freq_select1, 4);
        chk("s3_edge_freq2", freq_select2, 20);

        // B = 21 just above FREQ_MAX
        set_waves(8'd8, 1'b1, 8'd21, 1'b0);
        start_and_capture();
        tick();
        chk("s3_max_err", err, 1);
        chk("s3_max_keep", freq_select2, 20);

        // Timeout: 16 cycles in WAIT_VALID
        wave_vaild = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("s4_no_err_yet", err, 0);
        chk("s4_busy_yet", busy, 1);
        tick();
        chk("s4_err", err, 1);
        chk("s4_busy_off", busy, 0);

        // Phase trim in RUN
        set_waves(8'd8, 1'b1, 8'd12, 1'b0);
        start_and_capture();
        tick();
        chk("s5_loaded", cfg_done, 1);
        for (int i = 0; i < 65; i++) begin
            phase_up = 1'b1;
            tick();
            phase_up = 1'b0;
            tick();
        end
        chk("s5_up65", phase_select2, TRIM ? 1 : 0);
        phase_down = 1'b1;
        tick();
        phase_down = 1'b0;
        chk("s5_down_to0", phase_select2, 0);
        phase_down = 1'b1;
        tick();
        phase_down = 1'b0;
        chk("s5_wrap63", phase_select2, TRIM ? 63 : 0);
        phase_up   = 1'b1;
        phase_down = 1'b1;
        tick();
        phase_up   = 1'b0;
        phase_down = 1'b0;
        chk("s5_both", phase_select2, TRIM ? 63 : 0);
        chk("s5_phase1", phase_select1, 0);
        start    = 1'b1;
        phase_up = 1'b1;
        tick();
        start    = 1'b0;
        phase_up = 1'b0;
        chk("s5_start_wins", phase_select2, TRIM ? 63 : 0);
        chk("s5_start_busy", busy, 1);

        // Asynchronous reset during CHECK
        tick();
        wave_vaild = 1'b1;
        tick();
        wave_vaild = 1'b0;
        chk("s6_in_check", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_freq1", freq_select1, 0);
        chk("s6_rst_freq2", freq_select2, 0);
        chk("s6_rst_wave1", wave_select1, 0);
        chk("s6_rst_phase2", phase_select2, 0);
        tick();
        rst = 1'b0;
        tick();
        // IDLE ignores valid and phase pulses
        wave_vaild = 1'b1;
        phase_up   = 1'b1;
        tick();
        wave_vaild = 1'b0;
        tick();
        tick();
        phase_up = 1'b0;
        chk("s6_idle_busy", busy, 0);
        chk("s6_idle_done", cfg_done, 0);
        chk("s6_idle_freq1", freq_select1, 0);
        chk("s6_idle_phase2", phase_select2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dds_cfg_ctrl.md
# dds_cfg_ctrl

Sequencer between the FFT frequency-separation stage and the dual-channel DDS. After each start request it waits for a fresh separation result, range-checks it, and loads the DDS channel 1 and channel 2 wave, frequency and phase selects. It also owns the user phase trim of channel 2, applied while the regenerated outputs are running. Runs in the 100 MHz control domain.

## Interface
- TIMEOUT_CYCLES, 100_000_000: maximum cycles spent in WAIT_VALID before ERROR.
- FREQ_MIN, 4: lowest legal frequency code (code × 5 kHz).
- FREQ_MAX, 20: highest legal frequency code.
- clk  in  1  control clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse (debounced key); (re)starts a capture.
- wave_vaild  in  1  separation result valid (level).
- waveA_freq  in  8  channel A frequency code.
- waveA_sin  in  1  1 = A is sine, 0 = triangle.
- waveB_freq  in  8  channel B frequency code.
- waveB_sin  in  1  1 = B is sine, 0 = triangle.
- phase_up  in  1  one-cycle pulse; channel 2 phase +1 step.
- phase_down  in  1  one-cycle pulse; channel 2 phase −1 step.
- wave_select1 / wave_select2  out  1  DDS waveform selects.
- freq_select1 / freq_select2  out  8  DDS frequency selects.
- phase_select1 / phase_select2  out  6  DDS phase selects (64 steps per period).
- busy  out  1  high in WAIT_VALID and CHECK.
- cfg_done  out  1  one-cycle pulse when a new configuration is loaded.
- err  out  1  sticky error flag; cleared by the next start.

## Operation
- States: IDLE, WAIT_VALID, CHECK, RUN, ERROR. Reset state: IDLE.
- IDLE/RUN/ERROR + start → WAIT_VALID. On that edge: clear err, clear the arm flag, and zero the timeout counter.
- start while in WAIT_VALID or CHECK → re-enter WAIT_VALID with the same clears (restart). Outputs keep their last loaded values.
- WAIT_VALID arming: capture is accepted only after wave_vaild has been sampled low for at least one cycle since entry. A result left over from a previous run is therefore never reused.
- WAIT_VALID + armed + wave_vaild=1 → latch the four wave inputs, go to CHECK.
- WAIT_VALID with counter reaching TIMEOUT_CYCLES−1 → ERROR, err=1.
- CHECK: both codes must lie within FREQ_MIN..FREQ_MAX inclusive.
  - Pass → RUN. Load the selects: select1 from A, select2 from B; wave_select = the sin flag; phase_select1 = 0, phase_select2 = 0. Pulse cfg_done.
  - Fail → ERROR, err=1, outputs unchanged.
- RUN: phase_up increments phase_select2 modulo 64 (63→0); phase_down decrements it (0→63).
  - Both pulses in the same cycle: no change.
  - Phase pulses outside RUN are ignored.
  - phase_select1 is never trimmed.
- Reset values: every select output = 0 (freq_select 0 = DDS idle), busy=0, cfg_done=0, err=0.

## Timing
- start sampled at edge N → busy=1 from cycle N+1.
- Armed wave_vaild sampled high at edge M → CHECK during cycle M+1.
- On pass, the new selects and cfg_done are visible in cycle M+2; busy=0 in M+2. Total latency from valid to outputs: 2 cycles.
- Phase trim is registered: a pulse at edge K changes phase_select2 in cycle K+1.
- start coinciding with a phase pulse in RUN: start wins; the phase pulse is dropped.
- rst asserted mid-operation: all outputs return to reset values immediately (asynchronously); state becomes IDLE.
- Timeout counter width is $clog2(TIMEOUT_CYCLES). Counter is held at zero outside WAIT_VALID.

## Configuration
- PHASE_TRIM_EN defined: phase_up and phase_down operate as described in RUN.
- PHASE_TRIM_EN undefined: phase inputs are ignored, phase_select2 stays 0, and the trim logic is not built.

## Test plan
- Reset, then start. Drive wave_vaild low then high with A=8 sine, B=12 triangle. Expect freq_select1=8, wave_select1=1, freq_select2=12, wave_select2=0, cfg_done pulse exactly 2 cycles after valid.
- wave_vaild held high across start: no capture until it drops for one cycle and rises again; then load occurs.
- A=3 (below FREQ_MIN) → ERROR, err=1, outputs retain the previous configuration. The next start clears err.
- TIMEOUT_CYCLES=16 with no valid → err=1 at cycle 16 after entry, busy=0.
- In RUN with PHASE_TRIM_EN defined: 65 phase_up pulses → phase_select2=1. Then a phase_down from 0 gives 63. Simultaneous up+down leaves the value unchanged.
- Assert rst during CHECK → all outputs 0 immediately, state IDLE. Repeat the first scenario with PHASE_TRIM_EN undefined: phase pulses leave phase_select2=0.
